key_move_encoder: RTL and testbench

- Input conditioner that sits directly upstream of the game core and drives its 3-bit `go` move code.
- Takes the four raw active-low push-buttons, synchronises and debounces them, and priority-encodes them.
- Emits exactly one single-cycle move code per physical press: 001 up, 010 down, 011 left, 100 right, 000 idle.
- Replaces level-sampled key handling, so one press yields exactly one tile move and one movement-count increment.

---
 rtl/key_move_encoder.sv | 111 +++++++++++
 tb/tb_key_move_encoder.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_move_encoder.sv
// Push-button conditioner for the game core: synchronises and debounces the four
// active-low keys and emits one single-cycle move code per physical press.
module key_move_encoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_n,
  output logic [2:0] go,
  output logic       busy,
  output logic [7:0] press_count
);

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    FIRE,
    HELD,
    DB_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       pressed;
  logic [2:0]       enc;
  logic [2:0]       cand;
  logic [CNT_W-1:0] cnt;
  state_t           state;

  assign pressed = ~sync2;

  // Up outranks down outranks left outranks right.
  always_comb begin
    enc = 3'b000;
    if (pressed[3])      enc = 3'b001;
    else if (pressed[2]) enc = 3'b010;
    else if (pressed[1]) enc = 3'b011;
    else if (pressed[0]) enc = 3'b100;
  end

  // go is a one-cycle strobe with no backpressure: the game core must accept it
  // in the cycle it is non-zero; busy and press_count are plain status levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= 4'b1111;
      sync2       <= 4'b1111;
      state       <= IDLE;
      cnt         <= '0;
      cand        <= 3'b000;
      go          <= 3'b000;
      busy        <= 1'b0;
      press_count <= 8'd0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      go    <= 3'b000;
      case (state)
        IDLE: begin
          if (enc != 3'b000) begin
            cand  <= enc;
            cnt   <= '0;
            state <= DB_PRESS;
            busy  <= 1'b1;
          end
        end
        DB_PRESS: begin
          // Any change of the encoded key, including a higher-priority key
          // joining, abandons this candidate and restarts from IDLE.
          if (enc != cand) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state       <= FIRE;
            go          <= cand;
            press_count <= press_count + 8'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIRE: begin
          state <= HELD;
        end
        HELD: begin
          if (pressed == 4'b0000) begin
            cnt   <= '0;
            state <= DB_RELEASE;
          end
        end
        DB_RELEASE: begin
          if (pressed != 4'b0000) begin
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_move_encoder.sv
// Self-checking bench for key_move_encoder: directed scenarios plus random key
// activity, all compared against a timestamp-based reference model.
module tb_key_move_encoder;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_n;
  logic [2:0] go;
  logic       busy;
  logic [7:0] press_count;

  int checks = 0;
  int errors = 0;

  key_move_encoder #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_n(key_n),
    .go(go),
    .busy(busy),
    .press_count(press_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Keys reach the decision logic two edges after they are sampled. A press is
  // accepted once the same non-zero code has been seen D+1 edges in a row
  // (the edge that broke an earlier candidate does not start a new one); the
  // design then stays unarmed until D+1 consecutive all-released samples occur,
  // ignoring the sample on the edge right after the pulse.
  logic [3:0] kd1 = 4'b1111;
  logic [3:0] kd2 = 4'b1111;
  logic       m_armed = 1'b1;
  int         m_cand = 0;
  int         m_start = 0;
  int         edge_n = 0;
  int         m_zero_run = 0;
  logic       m_skip = 1'b0;
  logic [2:0] m_go = 3'b000;
  logic       m_busy = 1'b0;
  logic [7:0] m_count = 8'd0;
  logic       started = 1'b0;
  logic [2:0] exp_q[$];

  function automatic int enc_model(input logic [3:0] p);
    for (int i = 3; i >= 0; i--)
      if (p[i]) return 4 - i;
    return 0;
  endfunction

  always @(posedge clk) begin
    logic [3:0] p;
    int code;
    started = 1'b1;
    if (reset) begin
      kd1 = 4'b1111; kd2 = 4'b1111;
      m_armed = 1'b1; m_cand = 0; m_start = 0; edge_n = 0;
      m_zero_run = 0; m_skip = 1'b0; m_go = 3'b000; m_count = 8'd0;
      exp_q.delete();
    end else begin
      p = ~kd2;
      kd2 = kd1;
      kd1 = key_n;
      code = enc_model(p);
      edge_n++;
      m_go = 3'b000;
      if (m_armed) begin
        if (m_cand == 0) begin
          if (code != 0) begin
            m_cand = code;
            m_start = edge_n;
          end
        end else if (code != m_cand) begin
          m_cand = 0;
        end else if (edge_n - m_start == D) begin
          m_go = 3'(m_cand);
          m_count = m_count + 8'd1;
          exp_q.push_back(3'(m_cand));
          m_armed = 1'b0;
          m_cand = 0;
          m_skip = 1'b1;
          m_zero_run = 0;
        end
      end else if (m_skip) begin
        m_skip = 1'b0;
      end else begin
        m_zero_run = (p == 4'b0000) ? m_zero_run + 1 : 0;
        if (m_zero_run == D + 1) m_armed = 1'b1;
      end
    end
    m_busy = !(m_armed && m_cand == 0);
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [2:0] e;
    if (started) begin
      checks++;
      if ({go, busy, press_count} !== {m_go, m_busy, m_count}) begin
        errors++;
        $display("FAIL model_cycle t=%0t: go=%b busy=%b count=%0d expected go=%b busy=%b count=%0d",
                 $time, go, busy, press_count, m_go, m_busy, m_count);
      end
      if (go !== 3'b000) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pulse_unexpected t=%0t: go=%b expected no pulse", $time, go);
        end else begin
          e = exp_q.pop_front();
          if (go !== e) begin
            errors++;
            $display("FAIL pulse_code t=%0t: go=%b expected %b", $time, go, e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic hold(input logic [3:0] pat, input int n, output int pulses, output logic [2:0] last);
    pulses = 0;
    last = 3'b000;
    key_n = pat;
    repeat (n) begin
      @(negedge clk);
      if (go !== 3'b000) begin
        pulses++;
        last = go;
      end
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int pulses; logic [2:0] last;
    key_n = 4'b0000;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({go, busy, press_count} !== {3'b000, 1'b0, 8'd0}) begin
        errors++;
        $display("FAIL reset_values: go=%b busy=%b count=%0d expected 000/0/0", go, busy, press_count);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (go !== ((i == D + 2) ? 3'b001 : 3'b000)) begin
        errors++;
        $display("FAIL reset_release_latency edge k+%0d: go=%b expected %b", i, go,
                 (i == D + 2) ? 3'b001 : 3'b000);
      end
    end
    hold(4'b1111, 12, pulses, last);
  endtask

  task automatic test_single_press();
    int pulses; logic [2:0] last;
    key_n = 4'b1101;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (go !== ((i == D + 2) ? 3'b011 : 3'b000)) begin
        errors++;
        $display("FAIL left_latency edge k+%0d: go=%b expected %b", i, go,
                 (i == D + 2) ? 3'b011 : 3'b000);
      end
    end
    hold(4'b1111, 20, pulses, last);
    checks++;
    if ({busy, press_count} !== {1'b0, 8'd2}) begin
      errors++;
      $display("FAIL left_after_release: busy=%b count=%0d expected 0/2", busy, press_count);
    end
  endtask

  task automatic test_bounce();
    int p1, p2; logic [2:0] last;
    hold(4'b1110, 2, p1, last);
    hold(4'b1111, 10, p2, last);
    checks++;
    if ({p1 + p2, busy, press_count} !== {32'd0, 1'b0, 8'd2}) begin
      errors++;
      $display("FAIL press_bounce: pulses=%0d busy=%b count=%0d expected 0/0/2", p1 + p2, busy, press_count);
    end
  endtask

  task automatic test_simultaneous();
    int pulses; logic [2:0] last;
    hold(4'b1010, 20, pulses, last);
    checks++;
    if (pulses != 1 || last !== 3'b010) begin
      errors++;
      $display("FAIL simultaneous: pulses=%0d code=%b expected 1 pulse of 010", pulses, last);
    end
    hold(4'b1110, 20, pulses, last);
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL partial_release: pulses=%0d expected 0", pulses);
    end
    hold(4'b1111, 20, pulses, last);
    hold(4'b1110, 20, pulses, last);
    checks++;
    if (pulses != 1 || last !== 3'b100) begin
      errors++;
      $display("FAIL repress_right: pulses=%0d code=%b expected 1 pulse of 100", pulses, last);
    end
    hold(4'b1111, 20, pulses, last);
  endtask

  task automatic test_priority_upgrade();
    int p1, p2; logic [2:0] last;
    hold(4'b1110, 3, p1, last);
    hold(4'b1100, 20, p2, last);
    checks++;
    if (p1 + p2 != 1 || last !== 3'b011) begin
      errors++;
      $display("FAIL priority_upgrade: pulses=%0d code=%b expected 1 pulse of 011", p1 + p2, last);
    end
    hold(4'b1111, 20, p1, last);
  endtask

  task automatic test_release_bounce();
    int p0, p1, p2, p3; logic [2:0] last;
    hold(4'b0111, 12, p0, last);
    hold(4'b1111, 2, p1, last);
    hold(4'b0111, 1, p2, last);
    hold(4'b1111, 10, p3, last);
    checks++;
    if (p0 != 1 || p1 + p2 + p3 != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL release_bounce: first=%0d extra=%0d busy=%b expected 1/0/0", p0, p1 + p2 + p3, busy);
    end
    hold(4'b0111, 12, p0, last);
    checks++;
    if (p0 != 1 || last !== 3'b001) begin
      errors++;
      $display("FAIL after_release_bounce: pulses=%0d code=%b expected 1 pulse of 001", p0, last);
    end
    hold(4'b1111, 12, p0, last);
  endtask

  task automatic test_wrap();
    int total, pulses; logic [2:0] last;
    pulse_reset();
    total = 0;
    for (int n = 0; n < 256; n++) begin
      hold(4'b0111, 8, pulses, last);
      total += pulses;
      hold(4'b1111, 8, pulses, last);
      total += pulses;
    end
    checks++;
    if (total != 256 || press_count !== 8'd0) begin
      errors++;
      $display("FAIL count_wrap: pulses=%0d count=%0d expected 256/0", total, press_count);
    end
  endtask

  task automatic test_reset_mid();
    int pulses; logic [2:0] last;
    hold(4'b1011, 4, pulses, last);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({go, busy, press_count} !== {3'b000, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_mid: go=%b busy=%b count=%0d expected 000/0/0", go, busy, press_count);
    end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (go !== ((i == D + 2) ? 3'b010 : 3'b000)) begin
        errors++;
        $display("FAIL held_through_reset edge k+%0d: go=%b expected %b", i, go,
                 (i == D + 2) ? 3'b010 : 3'b000);
      end
    end
    hold(4'b1111, 12, pulses, last);
  endtask

  task automatic test_random();
    int pulses; logic [2:0] last;
    logic [3:0] pat;
    for (int s = 0; s < 200; s++) begin
      pat = ($urandom_range(0, 2) == 0) ? 4'b1111 : 4'($urandom);
      hold(pat, $urandom_range(1, 10), pulses, last);
    end
    hold(4'b1111, 12, pulses, last);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    key_n = 4'b1111;
    reset = 1'b1;
    test_reset();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_priority_upgrade();
    test_release_bounce();
    test_random();
    test_wrap();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected pulses never seen, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
